rr_arbiter16: RTL and testbench
===============================

Name: rr_arbiter16

Overview:
- 16-requester round-robin arbiter that shares a single resource among 16 requesters.
- Selection uses a rotating-priority search: the same masked "first set bit" selection the team's priority encoders perform, with the start point rotated after every grant.
- Grants are registered, one-hot and held until the owner releases its request.
- Sits in front of any shared datapath; downstream logic uses gnt_id as a mux select.

Parameters:
MAX_HOLD, 8, maximum consecutive grant cycles before forced release (only used when ARB_TIMEOUT_EN is defined); legal range 1..255.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
req  input  16  request vector, req[i] high = requester i wants the resource; level-sensitive
gnt  output  16  registered one-hot grant vector, all-zero when idle
gnt_id  output  4  binary index of the current grant holder; last holder while idle
gnt_valid  output  1  high while any gnt bit is high
timeout  output  1  one-cycle pulse when a grant is force-released (tied 0 without ARB_TIMEOUT_EN)

Behaviour:
- Reset (async, immediate on rst=1, independent of clk):
  - gnt=0, gnt_valid=0, gnt_id=0, timeout=0.
  - ptr=15, so req[0] has top priority after reset.
  - state=IDLE, hold_cnt=0.
- State IDLE:
  - If req==0: stay IDLE, outputs unchanged (gnt=0).
  - Else select winner w = first set bit in search order ptr+1, ptr+2, ..., ptr (mod 16).
  - Next edge: gnt<=1<<w, gnt_id<=w, gnt_valid<=1, ptr<=w, hold_cnt<=1, state<=GRANT.
- State GRANT:
  - If req[gnt_id]==1: hold the grant; hold_cnt increments, saturating at 255.
  - If req[gnt_id]==0: next edge gnt<=0, gnt_valid<=0, state<=IDLE; gnt_id keeps its last value.
- Timing:
  - Latency: request sampled in IDLE at edge N gives gnt at edge N+1.
  - Exactly one idle (gnt=0) cycle always separates consecutive grants, even if other requests are pending.
- Fairness:
  - The just-served index becomes lowest priority.
  - With all 16 requesting continuously and each releasing after its grant, the grant order is 0,1,...,15,0,...
- Request changes while granted:
  - Only req[gnt_id] is examined; other bits have no effect until IDLE.
  - The owner dropping and re-raising req within the same clock period is invisible; only sampled values count.
- Reset mid-grant:
  - gnt drops asynchronously, ptr returns to 15.
  - The first post-reset arbitration happens on the first rising edge with rst=0.
- Invariants:
  - gnt is always zero or one-hot.
  - gnt_valid == |gnt.
  - gnt[gnt_id]==1 whenever gnt_valid.
- X on req is not permitted; the bench asserts req is known out of reset.

Optional Feature:
Macro ARB_TIMEOUT_EN.
- Defined:
  - In GRANT, if hold_cnt==MAX_HOLD and req[gnt_id] is still 1, the next edge forces gnt<=0, gnt_valid<=0, state<=IDLE and pulses timeout=1 for exactly that one cycle.
  - ptr already equals the forced holder, so it becomes lowest priority in the next arbitration.
  - If it is the only requester it is re-granted after the idle cycle.
  - A normal release at the same edge takes precedence: no timeout pulse.
- Not defined:
  - No hold limit; grants are held indefinitely.
  - The timeout port exists and is constant 0.
  - No hold_cnt logic is synthesised.

Test Plan:
1. Reset:
   - Stimulus: rst=1 with req=16'hFFFF, clk running.
   - Required: gnt=16'h0000, gnt_valid=0, gnt_id=0, timeout=0 throughout.
   - Then release rst: gnt=16'h0001 one edge later.
2. Single requester:
   - Stimulus: req=16'h0020 for 3 cycles, then 0.
   - Required: gnt=16'h0020, gnt_id=5 from one edge after the request, held while req[5]=1, gnt=0 one edge after req[5] samples low.
3. Full rotation:
   - Stimulus: req=16'hFFFF, bench clears bit i for one cycle right after each grant to i.
   - Required: grants 0,1,2,...,15,0 with one idle cycle between each.
4. Rotation wrap:
   - Stimulus: after a grant to 7 releases, req=16'h1008.
   - Required: gnt=16'h1000 (id 12) first, then after its release gnt=16'h0008 (id 3).
5. Reset mid-grant:
   - Stimulus: gnt holding id 9, assert rst between clock edges.
   - Required: gnt=0 immediately; after reset release with req=16'h0202, id 1 wins (ptr=15).
6. Timeout (ARB_TIMEOUT_EN, MAX_HOLD=4):
   - Stimulus: req[2] and req[9] held high.
   - Required: gnt=16'h0004 for 4 cycles, timeout pulses 1 cycle, idle cycle, then gnt=16'h0200.

Source files
------------

// File: rtl/rr_arbiter16.sv
// 16-way round-robin arbiter with registered one-hot grant; grant 1 edge after request, held until release.
// Define ARB_TIMEOUT_EN to add a MAX_HOLD-cycle forced release with a one-cycle timeout pulse.
module rr_arbiter16 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req,
    output logic [15:0] gnt,
    output logic [3:0]  gnt_id,
    output logic        gnt_valid,
    output logic        timeout
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t      state, state_nxt;
    logic [3:0]  ptr, ptr_nxt;
    logic [3:0]  gnt_id_nxt;
    logic [15:0] gnt_nxt;
    logic [3:0]  win, idx;
    logic        found;

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
        $error("MAX_HOLD out of range 1..255");
    end

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_cnt, hold_cnt_nxt;
    logic       timeout_nxt;
`endif

    // Rotating search: ptr+1 first, ptr itself last, so the last winner has lowest priority.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= 16; k++) begin
            idx = ptr + 4'(k);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        gnt_nxt      = gnt;
        gnt_id_nxt   = gnt_id;
        ptr_nxt      = ptr;
`ifdef ARB_TIMEOUT_EN
        hold_cnt_nxt = hold_cnt;
        timeout_nxt  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (found) begin
                    gnt_nxt    = 16'h0001 << win;
                    gnt_id_nxt = win;
                    ptr_nxt    = win;
                    state_nxt  = GRANT;
`ifdef ARB_TIMEOUT_EN
                    hold_cnt_nxt = 8'd1;
`endif
                end
            end
            GRANT: begin
                if (!req[gnt_id]) begin
                    gnt_nxt   = '0;
                    state_nxt = IDLE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (hold_cnt == 8'(MAX_HOLD)) begin
                    gnt_nxt     = '0;
                    state_nxt   = IDLE;
                    timeout_nxt = 1'b1;
                end else if (hold_cnt != 8'hFF) begin
                    hold_cnt_nxt = hold_cnt + 8'd1;
                end
`endif
            end
            default: begin
                gnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            ptr       <= 4'hF;
        end else begin
            state     <= state_nxt;
            gnt       <= gnt_nxt;
            gnt_id    <= gnt_id_nxt;
            gnt_valid <= |gnt_nxt;
            ptr       <= ptr_nxt;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            hold_cnt <= hold_cnt_nxt;
            timeout  <= timeout_nxt;
        end
    end
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter16.sv
// Randomized and directed bench for rr_arbiter16 against a queue-free behavioural arbiter model.
module tb_rr_arbiter16;

    localparam int MAXH = 4;

    logic        clk;
    logic        rst;
    logic [15:0] req;
    logic [15:0] gnt;
    logic [3:0]  gnt_id;
    logic        gnt_valid;
    logic        timeout;

    int tests;
    int fails;

    // behavioural model: who owns the resource and who was served last
    bit         m_busy;
    logic [3:0] m_id;
    logic [3:0] m_last;
    int         m_cnt;
    bit         m_to;

    rr_arbiter16 #(.MAX_HOLD(MAXH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst) assert (!$isunknown(req));
    end

    task automatic model_reset();
        m_busy = 0;
        m_id   = 4'd0;
        m_last = 4'd15;
        m_cnt  = 0;
        m_to   = 0;
    endtask

    task automatic model_step();
        m_to = 0;
        if (!m_busy) begin
            for (int k = 1; k <= 16; k++) begin
                int w;
                w = (int'(m_last) + k) % 16;
                if (req[w]) begin
                    m_busy = 1;
                    m_id   = 4'(w);
                    m_last = 4'(w);
                    m_cnt  = 1;
                    break;
                end
            end
        end else if (!req[m_id]) begin
            m_busy = 0;
        end else begin
`ifdef ARB_TIMEOUT_EN
            if (m_cnt == MAXH) begin
                m_busy = 0;
                m_to   = 1;
            end else if (m_cnt < 255) begin
                m_cnt = m_cnt + 1;
            end
`endif
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        #1;
    endtask

    function automatic logic [21:0] expv();
        logic [15:0] g;
        g = m_busy ? (16'h0001 << m_id) : 16'h0000;
        return {g, m_id, m_busy, m_to};
    endfunction

    function automatic logic [21:0] actv();
        return {gnt, gnt_id, gnt_valid, timeout};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        req = 16'hFFFF;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            tests++;
            if (actv() !== 22'h0) begin
                fails++;
                $display("FAIL reset_state cyc%0d: got %h want 0", i, actv());
            end
        end
        rst = 1'b0;
        step();
        tests++;
        if (gnt !== 16'h0001 || actv() !== expv()) begin
            fails++;
            $display("FAIL reset_release: gnt=%h want 0001 (all %h vs %h)", gnt, actv(), expv());
        end
    endtask

    task automatic test_single();
        req = 16'h0000;
        step();
        req = 16'h0020;
        for (int i = 0; i < 3; i++) begin
            step();
            tests++;
            if (gnt !== 16'h0020 || gnt_id !== 4'd5 || actv() !== expv()) begin
                fails++;
                $display("FAIL single_hold cyc%0d: gnt=%h id=%0d want 0020/5", i, gnt, gnt_id);
            end
        end
        req = 16'h0000;
        step();
        tests++;
        if (gnt !== 16'h0000 || gnt_id !== 4'd5 || actv() !== expv()) begin
            fails++;
            $display("FAIL single_release: gnt=%h id=%0d want 0000/5", gnt, gnt_id);
        end
    endtask

    task automatic test_rotation();
        int ngr;
        bit prev;
        ngr  = 0;
        prev = 0;
        rst  = 1'b1;
        req  = 16'hFFFF;
        step();
        rst = 1'b0;
        for (int c = 0; c < 80 && ngr < 17; c++) begin
            step();
            tests++;
            if (actv() !== expv()) begin
                fails++;
                $display("FAIL rotation_cycle c%0d: got %h want %h", c, actv(), expv());
            end
            if (m_busy && !prev) begin
                tests++;
                if (gnt_id !== 4'(ngr % 16) || prev !== 1'b0) begin
                    fails++;
                    $display("FAIL rotation_order #%0d: id=%0d want %0d", ngr, gnt_id, ngr % 16);
                end
                ngr++;
                req = 16'hFFFF & ~(16'h0001 << m_id);
            end else begin
                req = 16'hFFFF;
            end
            prev = m_busy;
        end
        tests++;
        if (ngr != 17) begin
            fails++;
            $display("FAIL rotation_count: got %0d grants want 17", ngr);
        end
    endtask

    task automatic test_wrap();
        req = 16'h0000;
        step();
        step();
        req = 16'h0080;
        step();
        req = 16'h0000;
        step();
        req = 16'h1008;
        step();
        tests++;
        if (gnt !== 16'h1000 || gnt_id !== 4'd12 || actv() !== expv()) begin
            fails++;
            $display("FAIL wrap_first: gnt=%h id=%0d want 1000/12", gnt, gnt_id);
        end
        step();
        req = 16'h0008;
        step();
        step();
        tests++;
        if (gnt !== 16'h0008 || gnt_id !== 4'd3 || actv() !== expv()) begin
            fails++;
            $display("FAIL wrap_second: gnt=%h id=%0d want 0008/3", gnt, gnt_id);
        end
        req = 16'h0000;
        step();
    endtask

    task automatic test_reset_mid();
        req = 16'h0200;
        step();
        tests++;
        if (gnt !== 16'h0200 || gnt_id !== 4'd9) begin
            fails++;
            $display("FAIL midrst_grant: gnt=%h id=%0d want 0200/9", gnt, gnt_id);
        end
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        tests++;
        if (gnt !== 16'h0000 || actv() !== expv()) begin
            fails++;
            $display("FAIL midrst_async: got %h want 0", actv());
        end
        req = 16'h0202;
        step();
        tests++;
        if (actv() !== expv()) begin
            fails++;
            $display("FAIL midrst_held: got %h want %h", actv(), expv());
        end
        rst = 1'b0;
        step();
        tests++;
        if (gnt !== 16'h0002 || gnt_id !== 4'd1 || actv() !== expv()) begin
            fails++;
            $display("FAIL midrst_first: gnt=%h id=%0d want 0002/1", gnt, gnt_id);
        end
        req = 16'h0000;
        step();
    endtask

    task automatic test_hold_limit();
        int n2, n9, nto;
        n2  = 0;
        n9  = 0;
        nto = 0;
        req = 16'h0204;
        for (int i = 0; i < 10; i++) begin
            step();
            tests++;
            if (actv() !== expv()) begin
                fails++;
                $display("FAIL hold_cycle %0d: got %h want %h", i, actv(), expv());
            end
            if (gnt === 16'h0004) n2++;
            if (gnt === 16'h0200) n9++;
            if (timeout === 1'b1) nto++;
        end
        tests++;
`ifdef ARB_TIMEOUT_EN
        if (n2 != 4 || n9 != 4 || nto != 2) begin
            fails++;
            $display("FAIL hold_counts: n2=%0d n9=%0d to=%0d want 4/4/2", n2, n9, nto);
        end
`else
        if (n2 != 10 || n9 != 0 || nto != 0) begin
            fails++;
            $display("FAIL hold_counts: n2=%0d n9=%0d to=%0d want 10/0/0", n2, n9, nto);
        end
`endif
        req = 16'h0000;
        step();
        step();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3) == 0) req = 16'($urandom) & 16'($urandom);
            step();
            tests++;
            if (actv() !== expv()) begin
                fails++;
                $display("FAIL random_cycle %0d: req=%h got %h want %h", i, req, actv(), expv());
            end
            tests++;
            if (!$onehot0(gnt) || gnt_valid !== (|gnt) || (gnt_valid && !gnt[gnt_id])) begin
                fails++;
                $display("FAIL random_invariant %0d: gnt=%h id=%0d vld=%b", i, gnt, gnt_id, gnt_valid);
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        req   = 16'h0000;
        test_reset();
        test_single();
        test_rotation();
        test_wrap();
        test_reset_mid();
        test_hold_limit();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
